// File: rtl/video_multi_sprite_core.sv
// Sprite overlay stage: NUM_SPRITE chroma-keyed sprites with fixed index priority,
// double-buffered origins/enables, two-stage valid/ready pipeline with global stall.
package video_multi_sprite_pkg;
  typedef struct packed {
    logic [15:0] hc;
    logic [15:0] vc;
  } vga_fc_t;
endpackage

module video_multi_sprite_core
  import video_multi_sprite_pkg::*;
#(
  parameter int    RGB_SIZE      = 12,
  parameter int    NUM_SPRITE    = 4,
  parameter int    SPRITE_HSIZE  = 32,
  parameter int    SPRITE_VSIZE  = 32,
  parameter int    SPRITE_RAM_AW = 10,
  parameter string MEM_FILE      = ""
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         avs_write,
  input  logic [SPRITE_RAM_AW+$clog2(NUM_SPRITE):0]    avs_address,
  input  logic [31:0]                                  avs_writedata,
  input  logic                                         src_vld,
  output logic                                         src_rdy,
  input  vga_fc_t                                      src_fc,
  input  logic [RGB_SIZE-1:0]                          src_rgb,
  input  logic                                         snk_rdy,
  output logic                                         snk_vld,
  output vga_fc_t                                      snk_fc,
  output logic [RGB_SIZE-1:0]                          snk_rgb
);

  localparam int SEL_W  = $clog2(NUM_SPRITE);
  localparam int SEL_I  = (SEL_W > 0) ? SEL_W : 1;
  localparam int AW     = SPRITE_RAM_AW + SEL_W + 1;
  localparam int WORD_W = AW - 1;
  localparam int HW     = $clog2(SPRITE_HSIZE);
  localparam int DYW    = SPRITE_RAM_AW - HW;
  localparam int DEPTH  = 1 << SPRITE_RAM_AW;

  logic                      bypass;
  logic                      immediate_update;
  logic [RGB_SIZE-1:0]       chroma;
  logic [15:0]               pend_x [NUM_SPRITE];
  logic [15:0]               pend_y [NUM_SPRITE];
  logic [NUM_SPRITE-1:0]     pend_en;
  logic [15:0]               act_x  [NUM_SPRITE];
  logic [15:0]               act_y  [NUM_SPRITE];
  logic [NUM_SPRITE-1:0]     act_en;

  logic                      en;
  logic                      frame_start;
  logic                      reg_wr;
  logic                      ram_sel;
  logic [WORD_W-1:0]         word;
  logic [SEL_I-1:0]          ram_idx;
  logic [SPRITE_RAM_AW-1:0]  ram_pix;
  logic [16:0]               hc_ext;
  logic [16:0]               vc_ext;
  logic [NUM_SPRITE-1:0]     hit_c;
  logic [NUM_SPRITE-1:0][RGB_SIZE-1:0] ram_q;

  logic                      s1_vld;
  vga_fc_t                   s1_fc;
  logic [RGB_SIZE-1:0]       s1_rgb;
  logic [NUM_SPRITE-1:0]     s1_hit;
  logic [RGB_SIZE-1:0]       mix_rgb;
  logic                      unused_bits;

  assign en          = snk_rdy | ~snk_vld;
  assign src_rdy     = en;
  assign frame_start = src_vld & en & (src_fc.hc == 16'd0) & (src_fc.vc == 16'd0);
  assign ram_sel     = avs_address[AW-1];
  assign reg_wr      = avs_write & ~ram_sel;
  assign word        = avs_address[WORD_W-1:0];
  assign ram_pix     = avs_address[SPRITE_RAM_AW-1:0];
  assign hc_ext      = {1'b0, src_fc.hc};
  assign vc_ext      = {1'b0, src_fc.vc};
  assign unused_bits = &{1'b0, avs_writedata[31:16]};

  if (SEL_W > 0) begin : g_idx
    assign ram_idx = avs_address[AW-2 -: SEL_I];
  end else begin : g_noidx
    assign ram_idx = '0;
  end

  // Pending set takes bus writes; active set copies it at frame start (old value wins a same-cycle race).
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass           <= 1'b0;
      immediate_update <= 1'b0;
      chroma           <= '0;
      pend_en          <= '0;
      act_en           <= '0;
      for (int s = 0; s < NUM_SPRITE; s++) begin
        pend_x[s] <= '0;
        pend_y[s] <= '0;
        act_x[s]  <= '0;
        act_y[s]  <= '0;
      end
    end else begin
      if (reg_wr && word == WORD_W'(0)) begin
        bypass           <= avs_writedata[0];
        immediate_update <= avs_writedata[1];
      end
      if (reg_wr && word == WORD_W'(1))
        chroma <= avs_writedata[RGB_SIZE-1:0];
      for (int s = 0; s < NUM_SPRITE; s++) begin
        if (reg_wr && word == WORD_W'(4 + 4*s)) pend_x[s]  <= avs_writedata[15:0];
        if (reg_wr && word == WORD_W'(5 + 4*s)) pend_y[s]  <= avs_writedata[15:0];
        if (reg_wr && word == WORD_W'(6 + 4*s)) pend_en[s] <= avs_writedata[0];
        if (immediate_update || frame_start) begin
          act_x[s]  <= pend_x[s];
          act_y[s]  <= pend_y[s];
          act_en[s] <= pend_en[s];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITE; g++) begin : g_spr
    logic [16:0]               x0;
    logic [16:0]               y0;
    logic [HW-1:0]             dx;
    logic [DYW-1:0]            dy;
    logic [SPRITE_RAM_AW-1:0]  rd_addr;
    logic                      ram_we;
    logic [RGB_SIZE-1:0]       q;
    logic [RGB_SIZE-1:0]       mem [DEPTH];

    assign x0       = {1'b0, act_x[g]};
    assign y0       = {1'b0, act_y[g]};
    assign dx       = src_fc.hc[HW-1:0] - act_x[g][HW-1:0];
    assign dy       = src_fc.vc[DYW-1:0] - act_y[g][DYW-1:0];
    assign rd_addr  = {dy, dx};
    assign hit_c[g] = act_en[g] & (hc_ext >= x0) & (hc_ext < x0 + 17'(SPRITE_HSIZE))
                                & (vc_ext >= y0) & (vc_ext < y0 + 17'(SPRITE_VSIZE));
    assign ram_we   = avs_write & ram_sel & (ram_idx == SEL_I'(g));
    assign ram_q[g] = q;

    // Read-first RAM; output register holds while the pipeline is stalled.
    always_ff @(posedge clk) begin
      if (ram_we)
        mem[ram_pix] <= avs_writedata[RGB_SIZE-1:0];
      if (en)
        q <= mem[rd_addr];
    end
  end

  // Lowest index wins, so scan from the top down and let lower indices overwrite.
  always_comb begin
    mix_rgb = s1_rgb;
    if (!bypass) begin
      for (int s = NUM_SPRITE - 1; s >= 0; s--) begin
        if (s1_hit[s] && (ram_q[s] != chroma))
          mix_rgb = ram_q[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_fc   <= '0;
      s1_rgb  <= '0;
      s1_hit  <= '0;
      snk_vld <= 1'b0;
      snk_fc  <= '0;
      snk_rgb <= '0;
    end else if (en) begin
      s1_vld  <= src_vld;
      s1_fc   <= src_fc;
      s1_rgb  <= src_rgb;
      s1_hit  <= hit_c;
      snk_vld <= s1_vld;
      snk_fc  <= s1_fc;
      snk_rgb <= mix_rgb;
    end
  end

endmodule
